// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and constants for the fp_addsub_sched block.
//   FP_W       : IEEE-754 single-precision word width
//   FP_POS_ONE : +1.0
//   FP_QNAN    : canonical quiet NaN returned for invalid operations
//   ID_MAX_W   : widest requester ID supported (NUM_REQ up to 8)
//   s1_t       : operand-stage payload {a, b, sub, id}
package fp_addsub_sched_pkg;

  localparam int FP_W     = 32;
  localparam int ID_MAX_W = 3;

  localparam logic [FP_W-1:0] FP_POS_ONE = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic [FP_W-1:0]     a;
    logic [FP_W-1:0]     b;
    logic                sub;
    logic [ID_MAX_W-1:0] id;
  } s1_t;

endpackage

// File: rtl/fp_addsub.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// Denormal inputs and outputs are handled; NaN or inf-inf yields FP_QNAN.
//   a, b : operands
//   sub  : 1 = a - b, 0 = a + b
//   y    : result
module fp_addsub
  import fp_addsub_sched_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  output logic [FP_W-1:0] y
);

  logic        sa, sb, a_big, s_big, eff_sub;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  ea, eb, ea_eff, eb_eff, e_big, e_sml, diff;
  logic [23:0] ma, mb, m_big, m_sml;
  logic [53:0] align;
  logic [26:0] big_x, sml_x, norm;
  logic [27:0] sum;
  logic [9:0]  exp_r, sh, e_out;
  logic [24:0] rounded;

  always_comb begin
    sa      = a[31];
    sb      = b[31] ^ sub;
    ea      = a[30:23];
    eb      = b[30:23];
    ma      = {|ea, a[22:0]};
    mb      = {|eb, b[22:0]};
    a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
    // Denormals live at the exponent of the smallest normal, without hidden bit.
    ea_eff  = (ea == 8'd0) ? 8'd1 : ea;
    eb_eff  = (eb == 8'd0) ? 8'd1 : eb;
    a_big   = (a[30:0] >= b[30:0]);
    e_big   = a_big ? ea_eff : eb_eff;
    e_sml   = a_big ? eb_eff : ea_eff;
    m_big   = a_big ? ma : mb;
    m_sml   = a_big ? mb : ma;
    s_big   = a_big ? sa : sb;
    eff_sub = sa ^ sb;

    // Align the smaller operand: 3 extra bits (guard, round, sticky), with
    // everything shifted past the sticky position ORed into it.
    diff = e_big - e_sml;
    if (diff > 8'd27) diff = 8'd27;
    align = {m_sml, 3'b000, 27'd0} >> diff;
    big_x = {m_big, 3'b000};
    sml_x = {align[53:28], align[27] | (|align[26:0])};
    sum   = eff_sub ? ({1'b0, big_x} - {1'b0, sml_x})
                    : ({1'b0, big_x} + {1'b0, sml_x});

    exp_r = {2'b00, e_big};
    sh    = 10'd0;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_r = exp_r + 10'd1;
    end else begin
      sh = 10'd27;
      for (int i = 0; i < 27; i++) begin
        if (sum[i]) sh = 10'(26 - i);
      end
      // Never normalise below the minimum exponent: the result goes denormal.
      if (sh > exp_r - 10'd1) sh = exp_r - 10'd1;
      norm  = sum[26:0] << sh;
      exp_r = exp_r - sh;
    end

    rounded = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
    if (rounded[24])      e_out = exp_r + 10'd1;
    else if (rounded[23]) e_out = exp_r;
    else                  e_out = 10'd0;

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y = FP_QNAN;
    else if (a_inf)                                        y = {sa, 8'hFF, 23'd0};
    else if (b_inf)                                        y = {sb, 8'hFF, 23'd0};
    else if (sum == 28'd0)                                 y = {sa & sb, 31'd0};
    else if (e_out >= 10'd255)                             y = {s_big, 8'hFF, 23'd0};
    else y = {s_big, e_out[7:0], rounded[24] ? rounded[23:1] : rounded[22:0]};
  end

endmodule

// File: rtl/fp_addsub_sched_arb.sv
// Round-robin arbiter: scans req starting at ptr and grants the first set bit.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   grant   : one-hot grant (zero when no request)
//   gnt_idx : encoded index of the granted requester
//   gnt_any : some requester is granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!gnt_any && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = ID_W'(idx);
        gnt_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one fp_addsub datapath between NUM_REQ requesters with round-robin
// arbitration, an operand register (S1) and a result register (S2), and full
// backpressure. Results return in acceptance order tagged with requester ID.
// Optional macro FP_ADDSUB_SCHED_PERF_EN adds op/stall counters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b         : operands, requester i at [32*i +: 32]
//   req_sub              : per-requester 1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready  : result handshake
//   rsp_data, rsp_id     : result and issuing requester
//   perf_ops, perf_stall : completed ops / stalled response cycles (0 if disabled)
module fp_addsub_sched
  import fp_addsub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_stall
);

  s1_t              s1_q, s1_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [FP_W-1:0]  s2_data_q, s2_data_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any, adv2, accept, transfer;
  logic [FP_W-1:0]    fp_y;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  fp_addsub u_fp (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .sub (s1_q.sub),
    .y   (fp_y)
  );

  // S1 may move into S2 when S2 is empty or draining this cycle, so a full
  // pipeline still accepts one op per cycle.
  assign adv2     = v1_q & (~v2_q | rsp_ready);
  assign accept   = ~v1_q | adv2;
  // Qualified by rst_n so nothing is offered while reset is held.
  assign transfer = accept & gnt_any & rst_n;
  assign req_ready = transfer ? grant : '0;

  always_comb begin
    s1_d      = s1_q;
    v1_d      = v1_q;
    s2_data_d = s2_data_q;
    s2_id_d   = s2_id_q;
    v2_d      = v2_q;
    ptr_d     = ptr_q;

    if (transfer) begin
      s1_d.a   = req_a[FP_W*gnt_idx +: FP_W];
      s1_d.b   = req_b[FP_W*gnt_idx +: FP_W];
      s1_d.sub = req_sub[gnt_idx];
      s1_d.id  = ID_MAX_W'(gnt_idx);
      v1_d     = 1'b1;
      ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      s2_data_d = fp_y;
      s2_id_d   = ID_W'(s1_q.id);
      v2_d      = 1'b1;
    end else if (rsp_ready) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      v1_q      <= 1'b0;
      s2_data_q <= '0;
      s2_id_q   <= '0;
      v2_q      <= 1'b0;
      ptr_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_q      <= s1_d;
      v1_q      <= v1_d;
      s2_data_q <= s2_data_d;
      s2_id_q   <= s2_id_d;
      v2_q      <= v2_d;
      ptr_q     <= ptr_d;
    end
  end

  assign rsp_valid = v2_q;
  assign rsp_data  = s2_data_q;
  assign rsp_id    = s2_id_q;

`ifdef FP_ADDSUB_SCHED_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q   + {31'd0, v2_q &  rsp_ready};
    perf_stall_d = perf_stall_q + {31'd0, v2_q & ~rsp_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_ops   = 32'h0;
  assign perf_stall = 32'h0;
`endif

endmodule
